// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 16 x 8-bit register file to the bus and to a host read port.
// Optional feature macro: I2C_SLAVE_AUTOINC_EN (register pointer auto-increments per data byte).
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_out,
  input  logic [3:0] host_addr,
  output logic [7:0] host_data,
  output logic       wr_pulse,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_REG, S_ACK_REG,
    S_WR, S_ACK_WR, S_RD, S_RACK, S_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;
  logic r_scl_rise, r_scl_fall, r_start, r_stop;

  state_t        r_state, w_state;
  logic [2:0]    r_bitcnt, w_bitcnt;
  logic [DW-2:0] r_shift, w_shift;
  logic [AW-1:0] r_ptr, w_ptr;
  logic          r_rw, w_rw;
  logic          r_ack_seen, w_ack_seen;
  logic          r_sda_out, w_sda_out;
  logic          r_busy, w_busy;
  logic          r_wr_pulse;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_regs [NREGS];

  logic          w_commit;
  logic          w_last;
  logic [DW-1:0] w_byte;
  logic [DW-1:0] w_rd_byte;
  logic [AW-1:0] w_ptr_inc;

  // Synchronize pins; bus events are registered so they appear 3 clocks after a pin change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_h    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_h    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_s1   <= SCL_in;
      r_scl_s2   <= r_scl_s1;
      r_scl_h    <= r_scl_s2;
      r_sda_s1   <= SDA_in;
      r_sda_s2   <= r_sda_s1;
      r_sda_h    <= r_sda_s2;
      r_scl_rise <= r_scl_s2 & ~r_scl_h;
      r_scl_fall <= ~r_scl_s2 & r_scl_h;
      r_start    <= r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
      r_stop     <= r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
    end
  end

  assign w_byte    = {r_shift, r_sda_h};
  assign w_last    = (r_bitcnt == 3'd7);
  assign w_rd_byte = r_regs[r_ptr];

`ifdef I2C_SLAVE_AUTOINC_EN
  assign w_ptr_inc = r_ptr + 4'd1;
`else
  assign w_ptr_inc = r_ptr;
`endif

  // Next-state logic; START/STOP take priority over any SCL edge in the same cycle.
  always_comb begin
    w_state    = r_state;
    w_bitcnt   = r_bitcnt;
    w_shift    = r_shift;
    w_ptr      = r_ptr;
    w_rw       = r_rw;
    w_ack_seen = r_ack_seen;
    w_sda_out  = r_sda_out;
    w_busy     = r_busy;
    w_commit   = 1'b0;

    if (r_stop) begin
      w_state   = S_IDLE;
      w_sda_out = 1'b1;
    end else if (r_start) begin
      w_state   = S_DEV;
      w_bitcnt  = 3'd0;
      w_sda_out = 1'b1;
    end else begin
      case (r_state)
        S_DEV: begin
          if (r_scl_rise) begin
            w_shift  = w_byte[DW-2:0];
            w_bitcnt = r_bitcnt + 3'd1;
            if (w_last) begin
              w_rw       = w_byte[0];
              w_ack_seen = 1'b0;
              w_state    = (w_byte[7:1] == DEV_ADDR) ? S_ACK_DEV : S_IGNORE;
            end
          end
        end
        S_REG, S_WR: begin
          if (r_scl_rise) begin
            w_shift  = w_byte[DW-2:0];
            w_bitcnt = r_bitcnt + 3'd1;
            if (w_last) begin
              w_ack_seen = 1'b0;
              if (r_state == S_REG) begin
                w_ptr   = w_byte[AW-1:0];
                w_state = S_ACK_REG;
              end else begin
                w_commit = 1'b1;
                w_ptr    = w_ptr_inc;
                w_state  = S_ACK_WR;
              end
            end
          end
        end
        // First fall drives ACK low, the fall after the master's sampling rise ends it.
        S_ACK_DEV, S_ACK_REG, S_ACK_WR: begin
          if (r_scl_rise) begin
            w_ack_seen = 1'b1;
          end else if (r_scl_fall) begin
            if (!r_ack_seen) begin
              w_sda_out = 1'b0;
            end else begin
              w_sda_out = 1'b1;
              if (r_state == S_ACK_DEV && r_rw) begin
                w_state   = S_RD;
                w_shift   = w_rd_byte[DW-2:0];
                w_sda_out = w_rd_byte[DW-1];
              end else if (r_state == S_ACK_DEV) begin
                w_state = S_REG;
              end else begin
                w_state = S_WR;
              end
            end
          end
        end
        S_RD: begin
          if (r_scl_rise) begin
            w_bitcnt = r_bitcnt + 3'd1;
            if (w_last) begin
              w_ack_seen = 1'b0;
              w_state    = S_RACK;
            end
          end else if (r_scl_fall) begin
            w_sda_out = r_shift[DW-2];
            w_shift   = {r_shift[DW-3:0], 1'b0};
          end
        end
        S_RACK: begin
          if (r_scl_rise) begin
            w_ack_seen = 1'b1;
            if (r_sda_h) begin
              w_state = S_IGNORE;
            end else begin
              w_ptr = w_ptr_inc;
            end
          end else if (r_scl_fall) begin
            if (!r_ack_seen) begin
              w_sda_out = 1'b1;
            end else begin
              w_state   = S_RD;
              w_shift   = w_rd_byte[DW-2:0];
              w_sda_out = w_rd_byte[DW-1];
            end
          end
        end
        default: begin
          w_sda_out = 1'b1;
        end
      endcase
    end

    if (w_state == S_IDLE || w_state == S_IGNORE) begin
      w_busy = 1'b0;
    end else if (w_state == S_ACK_DEV) begin
      w_busy = 1'b1;
    end
  end

  // State, datapath and register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_ack_seen <= 1'b0;
      r_sda_out  <= 1'b1;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state    <= w_state;
      r_bitcnt   <= w_bitcnt;
      r_shift    <= w_shift;
      r_ptr      <= w_ptr;
      r_rw       <= w_rw;
      r_ack_seen <= w_ack_seen;
      r_sda_out  <= w_sda_out;
      r_busy     <= w_busy;
      r_wr_pulse <= w_commit;
      if (w_commit) begin
        r_regs[r_ptr] <= w_byte;
        r_wr_addr     <= r_ptr;
        r_wr_data     <= w_byte;
      end
    end
  end

  assign SDA_out   = r_sda_out;
  assign busy      = r_busy;
  assign wr_pulse  = r_wr_pulse;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign host_data = r_regs[host_addr];

endmodule
